// File: rtl/branch_cmp_pipe_if.sv
// branch_cmp_pipe_if: request/result handshake and statistics bundle for branch_cmp_pipe
interface branch_cmp_pipe_if #(parameter int WIDTH = 32, parameter int TAG_W = 5, parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] eval_cnt;
  logic [CNT_W-1:0] taken_cnt;
  modport master (
    output in_valid, op, a, b, in_tag, flush, out_ready,
    input  in_ready, out_valid, taken, illegal, out_tag, eval_cnt, taken_cnt
  );
  modport slave (
    input  in_valid, op, a, b, in_tag, flush, out_ready,
    output in_ready, out_valid, taken, illegal, out_tag, eval_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_cmp_pipe.sv
// branch_cmp_pipe: elastic pipelined branch-condition evaluator with flush and saturating statistics
module branch_cmp_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             reset,
  branch_cmp_pipe_if.slave bus
);
  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("branch_cmp_pipe: STAGES must be 1..3");
  end
  logic                neg, zero, cond_d, ill_d, out_hs;
  logic [STAGES+1:1]   rdy;
  logic [STAGES:1]     v_q, t_q, il_q;
  logic [TAG_W-1:0]    tag_q [1:STAGES];
  logic [CNT_W-1:0]    eval_q, taken_q;
  assign neg  = bus.a[WIDTH-1];
  assign zero = bus.a == '0;
  assign ill_d = &bus.op;
  assign cond_d = bus.op == 3'd0 ? bus.a == bus.b :
                  bus.op == 3'd1 ? bus.a != bus.b :
                  bus.op == 3'd2 ? neg || zero :
                  bus.op == 3'd3 ? !(neg || zero) :
                  bus.op == 3'd4 ? neg :
                  bus.op == 3'd5 ? !neg :
                  bus.op == 3'd6 ? $signed(bus.a) < $signed(bus.b) : 1'b0;
  // a stage can take new data when it is empty or its content moves on
  always_comb begin
    rdy[STAGES+1] = bus.out_ready;
    for (int s = STAGES; s >= 1; s--) rdy[s] = !v_q[s] || rdy[s+1];
  end
  assign out_hs = v_q[STAGES] && bus.out_ready && !bus.flush;
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      t_q     <= '0;
      il_q    <= '0;
      eval_q  <= '0;
      taken_q <= '0;
      for (int s = 1; s <= STAGES; s++) tag_q[s] <= '0;
    end else begin
      if (rdy[1]) begin
        v_q[1]   <= bus.in_valid && !bus.flush;
        t_q[1]   <= cond_d;
        il_q[1]  <= ill_d;
        tag_q[1] <= bus.in_tag;
      end
      for (int s = 2; s <= STAGES; s++) begin
        if (rdy[s]) begin
          v_q[s]   <= v_q[s-1];
          t_q[s]   <= t_q[s-1];
          il_q[s]  <= il_q[s-1];
          tag_q[s] <= tag_q[s-1];
        end
      end
      if (bus.flush) v_q <= '0;
      if (out_hs) begin
        eval_q  <= eval_q + CNT_W'(!(&eval_q));
        taken_q <= taken_q + CNT_W'(t_q[STAGES] && !(&taken_q));
      end
    end
  end
  assign bus.in_ready  = rdy[1] && !bus.flush;
  assign bus.out_valid = v_q[STAGES];
  assign bus.taken     = t_q[STAGES];
  assign bus.illegal   = il_q[STAGES];
  assign bus.out_tag   = tag_q[STAGES];
  assign bus.eval_cnt  = eval_q;
  assign bus.taken_cnt = taken_q;
endmodule

// File: tb/tb_branch_cmp_pipe.sv
// tb_branch_cmp_pipe: three DUTs (STAGES=1,2,3; the STAGES=2 one with 4-bit counters) driven in lockstep against a queue-level model
module tb_branch_cmp_pipe;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0, flush = 0, out_ready = 1;
  logic [2:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  logic [4:0]  in_tag = 0;
  logic        irdy [3];
  logic        ov [3];
  logic        tk [3];
  logic        il [3];
  logic [4:0]  ot [3];
  logic [15:0] ec [3];
  logic [15:0] tc [3];
  int vec = 0, mis = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int CW = (k == 1) ? 4 : 16;
    branch_cmp_pipe_if #(.WIDTH(32), .TAG_W(5), .CNT_W(CW)) bi ();
    assign bi.in_valid  = in_valid;
    assign bi.op        = op;
    assign bi.a         = a;
    assign bi.b         = b;
    assign bi.in_tag    = in_tag;
    assign bi.flush     = flush;
    assign bi.out_ready = out_ready;
    assign irdy[k] = bi.in_ready;
    assign ov[k]   = bi.out_valid;
    assign tk[k]   = bi.taken;
    assign il[k]   = bi.illegal;
    assign ot[k]   = bi.out_tag;
    assign ec[k]   = 16'(bi.eval_cnt);
    assign tc[k]   = 16'(bi.taken_cnt);
    branch_cmp_pipe #(.WIDTH(32), .STAGES(k + 1), .TAG_W(5), .CNT_W(CW)) dut (
      .clk(clk), .reset(rst), .bus(bi.slave)
    );
  end
  typedef struct {bit tk; bit il; bit [4:0] tag; int pos;} item_t;
  item_t m [3][3];
  int    n [3], ev [3], tcn [3];
  bit    arst;
  function automatic bit cond(bit [2:0] o, bit [31:0] x, bit [31:0] y);
    case (o)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd2: return $signed(x) <= 0;
      3'd3: return $signed(x) > 0;
      3'd4: return $signed(x) < 0;
      3'd5: return $signed(x) >= 0;
      3'd6: return $signed(x) < $signed(y);
      default: return 1'b0;
    endcase
  endfunction
  task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      mis++;
      $error("FAIL %s dut%0d got=%0h exp=%0h", nm, k, got, exp);
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int s = k + 1;
      int mx = (k == 1) ? 15 : 65535;
      bit acc = in_valid && !(n[k] == s && !out_ready) && !flush;
      if (rst) begin
        n[k] = 0; ev[k] = 0; tcn[k] = 0;
      end else if (flush) n[k] = 0;
      else begin
        if (n[k] > 0 && m[k][0].pos == s && out_ready) begin
          if (ev[k] < mx) ev[k]++;
          if (m[k][0].tk && tcn[k] < mx) tcn[k]++;
          for (int i = 0; i < n[k] - 1; i++) m[k][i] = m[k][i+1];
          n[k]--;
        end
        for (int i = 0; i < n[k]; i++)
          if (m[k][i].pos < s && (i == 0 || m[k][i-1].pos != m[k][i].pos + 1)) m[k][i].pos++;
        if (acc) begin
          m[k][n[k]] = '{cond(op, a, b), op == 3'd7, in_tag, 1};
          n[k]++;
        end
      end
    end
    arst = rst;
  endtask
  task automatic cyc();
    #2;
    if (!rst)
      for (int k = 0; k < 3; k++)
        chk("in_ready", k, 32'(irdy[k]), 32'(!(n[k] == k + 1 && !out_ready) && !flush));
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      bit v = n[k] > 0 && m[k][0].pos == k + 1;
      chk("out_valid", k, 32'(ov[k]), 32'(v));
      if (v) begin
        chk("taken", k, 32'(tk[k]), 32'(m[k][0].tk));
        chk("illegal", k, 32'(il[k]), 32'(m[k][0].il));
        chk("out_tag", k, 32'(ot[k]), 32'(m[k][0].tag));
      end else if (arst) begin
        chk("rst_taken", k, 32'(tk[k]), 0);
        chk("rst_illegal", k, 32'(il[k]), 0);
        chk("rst_tag", k, 32'(ot[k]), 0);
      end
      chk("eval_cnt", k, 32'(ec[k]), 32'(ev[k]));
      chk("taken_cnt", k, 32'(tc[k]), 32'(tcn[k]));
    end
  endtask
  task automatic drive(bit v, bit [2:0] o, bit [31:0] x, bit [31:0] y, bit [4:0] t, bit fl, bit ordy);
    in_valid = v; op = o; a = x; b = y; in_tag = t; flush = fl; out_ready = ordy;
    cyc();
  endtask
  task automatic idle(int c, bit ordy);
    for (int i = 0; i < c; i++) drive(0, 0, 0, 0, 0, 0, ordy);
  endtask
  initial begin
    rst = 1;
    idle(2, 1);
    rst = 0;
    drive(1, 3'd0, 32'h5, 32'h5, 5'd3, 0, 1);
    idle(4, 1);
    drive(1, 3'd4, 32'h8000_0000, 0, 5'd1, 0, 1);
    drive(1, 3'd5, 32'h8000_0000, 0, 5'd2, 0, 1);
    drive(1, 3'd2, 32'h0, 0, 5'd3, 0, 1);
    drive(1, 3'd3, 32'h0, 0, 5'd4, 0, 1);
    drive(1, 3'd6, 32'hFFFF_FFFF, 32'h1, 5'd5, 0, 1);
    drive(1, 3'd6, 32'h1, 32'hFFFF_FFFF, 5'd6, 0, 1);
    drive(1, 3'd7, 32'h5, 32'h5, 5'd7, 0, 1);
    drive(1, 3'd1, 32'h5, 32'h6, 5'd8, 0, 1);
    idle(4, 1);
    for (int t = 0; t < 5; t++) drive(1, 3'd0, 32'h9, 32'h9, 5'(t), 0, 0);
    idle(2, 0);
    idle(8, 1);
    drive(1, 3'd0, 32'h1, 32'h1, 5'd10, 0, 1);
    drive(1, 3'd0, 32'h1, 32'h2, 5'd11, 0, 1);
    drive(1, 3'd0, 32'h3, 32'h3, 5'd12, 1, 1);
    drive(1, 3'd5, 32'h3, 32'h0, 5'd13, 0, 1);
    idle(4, 1);
    for (int i = 0; i < 20; i++) drive(1, 3'd0, 32'(i), 32'(i), 5'(i), 0, 1);
    idle(4, 1);
    for (int i = 0; i < 3; i++) drive(1, 3'd3, 32'h7, 0, 5'(20 + i), 0, 0);
    rst = 1;
    idle(1, 1);
    rst = 0;
    idle(2, 1);
    for (int i = 0; i < 400; i++) begin
      bit [31:0] x = $urandom, y = $urandom;
      case ($urandom_range(0, 3))
        0: y = x;
        1: begin x = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0; y = 32'h7FFF_FFFF; end
        default: ;
      endcase
      drive($urandom_range(0, 3) != 0, 3'($urandom), x, y, 5'($urandom),
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end
    idle(6, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule

// File: doc/branch_cmp_pipe.md
Name: branch_cmp_pipe

Overview:
Parametrised, pipelined branch-condition evaluator for the MIPS core. Accepts two operands plus a compare opcode through a valid/ready handshake. Produces a registered taken/not-taken decision with a tag after STAGES cycles. Supports flush on pipeline redirect and keeps saturating statistics counters for evaluated and taken branches. Sits between operand forwarding in the decode stage and the PC-select logic; it supersedes the single-equality comparator.

Parameters:
WIDTH, 32, operand width in bits (>=2)
STAGES, 1, number of register stages from accept to output (1..3)
TAG_W, 5, width of the opaque tag carried alongside each evaluation
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents a compare request
in_ready  output  1  block can accept a request this cycle
op  input  3  compare opcode (encoding below)
a  input  WIDTH  operand rs
b  input  WIDTH  operand rt (ignored by zero-compare ops)
in_tag  input  TAG_W  request tag
flush  input  1  discard all in-flight requests
out_valid  output  1  result available
out_ready  input  1  downstream accepts the result
taken  output  1  branch condition true
illegal  output  1  opcode was reserved
out_tag  output  TAG_W  tag of the presented result
eval_cnt  output  CNT_W  completed evaluations, saturating
taken_cnt  output  CNT_W  completed taken evaluations, saturating

Behaviour:
- Opcodes:
  - 0 EQ: a==b
  - 1 NE: a!=b
  - 2 LEZ: signed a<=0
  - 3 GTZ: signed a>0
  - 4 LTZ: signed a<0
  - 5 GEZ: signed a>=0
  - 6 LT: signed a<b
  - 7 reserved: taken=0, illegal=1
- Signed compares use the full WIDTH, MSB is the sign bit. There is no overflow case, so compare directly rather than by subtraction without extension.
- The condition is computed combinationally at the input. Result, illegal and tag are captured in stage 1 on accept (in_valid && in_ready).
- The pipeline is elastic. Stage i holds valid_i and its payload. ready_i = !valid_i || ready_{i+1}; ready_{STAGES+1} = out_ready.
- in_ready = ready_1 && !flush.
- Each stage advances when its successor is ready. Stages compact through bubbles.
- out_valid, taken, illegal and out_tag come from the last stage.
- Latency: exactly STAGES cycles from accept to out_valid, provided out_ready was held high. Throughput is 1 result per cycle.
- Stall: while out_valid && !out_ready, all output signals hold stable. The pipeline fills, then in_ready drops.
- flush (cycle-synchronous):
  - all valid_i clear at the next edge;
  - no request is accepted that cycle;
  - a result handshaking in the same cycle as flush is discarded and not counted.
  - Payload registers need not clear.
- Counters:
  - on out_valid && out_ready && !flush, eval_cnt += 1 and taken_cnt += taken;
  - each counter saturates at all-ones and does not wrap;
  - illegal results count toward eval_cnt only.
- Reset (synchronous, priority over flush and handshakes): every valid_i=0, out_valid=0, taken=0, illegal=0, out_tag=0, eval_cnt=0, taken_cnt=0. in_ready is 1 in the first cycle after reset deasserts.
- Reset asserted mid-operation drops all in-flight results. No handshake completes in the reset cycle.
- Behaviour for STAGES outside 1..3 is undefined. Elaboration must fail via a generate-time check.

Test Plan:
- Reset, then STAGES=1, a=32'h5, b=32'h5, op=EQ, in_tag=3, out_ready=1 -> next cycle out_valid=1, taken=1, out_tag=3; eval_cnt=1, taken_cnt=1 after that cycle.
- Signed edges: a=32'h8000_0000 with op=LTZ -> taken=1 and with op=GEZ -> taken=0; a=0 with LEZ=1, GTZ=0; a=32'hFFFF_FFFF, b=1 with op=LT -> taken=1; op=7 -> taken=0, illegal=1, eval_cnt increments, taken_cnt unchanged.
- Backpressure with STAGES=3: 5 back-to-back requests, out_ready=0 -> in_ready falls after 3 accepts and outputs stay stable. Raise out_ready -> remaining requests drain in order, tags 0..4 with no loss or duplication, 1 per cycle.
- Flush with STAGES=2 and 2 requests in flight: assert flush alongside in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle, counters unchanged, next request after flush emerges with correct tag.
- Saturation with CNT_W=4: 20 taken EQ results -> eval_cnt and taken_cnt stick at 4'hF.
- Reset mid-stream with 3 in flight -> all outputs 0 the following cycle and both counters cleared.
